// File: rtl/i2c_target_regfile_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_PTR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h3C;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Pad-side I2C lines plus the fabric write-strobe / read port of the target.
interface i2c_target_regfile_if #(parameter int AW = 4);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] fab_rd_addr;
  logic [7:0]    fab_rd_data;
  logic          busy;

  modport slave (
    input  scl_i, sda_i, fab_rd_addr,
    output sda_oe, wr_strobe, wr_addr, wr_data, fab_rd_data, busy
  );

  modport master (
    output scl_i, sda_i, fab_rd_addr,
    input  sda_oe, wr_strobe, wr_addr, wr_data, fab_rd_data, busy
  );
endinterface

// File: rtl/i2c_target_regfile_filter.sv
// SCL/SDA conditioning: 2-FF sync, FILT_LEN stable-sample filter, edge and START/STOP pulses.
module i2c_bus_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int CW = $clog2(FILT_LEN + 1);

  // index 1 = SCL, index 0 = SDA
  logic [1:0]         raw;
  logic [1:0]         s1_q, s2_q, filt_q, prev_q;
  logic [1:0][CW-1:0] cnt_q;

  assign raw = {scl_i, sda_i};

  // Lines reset to 1 so an idle bus produces no spurious edges after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= '1;
      s2_q   <= '1;
      filt_q <= '1;
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_q[i] <= s2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign sda_o      = filt_q[0];
  assign scl_rise_o =  filt_q[1] & ~prev_q[1];
  assign scl_fall_o = ~filt_q[1] &  prev_q[1];
  assign start_o    =  prev_q[0] & ~filt_q[0] & filt_q[1] & prev_q[1];
  assign stop_o     = ~prev_q[0] &  filt_q[0] & filt_q[1] & prev_q[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte register file to the HPS; fabric gets a write strobe and a read port.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         NUM_REGS = 16,
  parameter int         FILT_LEN = 3
) (
  input  logic                 clk_50_clk,
  input  logic                 reset_50_reset,
  i2c_target_regfile_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic          sda_f, scl_rise, scl_fall, start, stop;
  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ack_q, ack_d;
  logic          rw_q, rw_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          reg_we;
  logic [7:0]    rd_byte;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    fab_rd_data_q;

  i2c_bus_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk_i      (clk_50_clk),
    .rst_i      (reset_50_reset),
    .scl_i      (bus.scl_i),
    .sda_i      (bus.sda_i),
    .sda_o      (sda_f),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  assign rd_byte = regs_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    ack_d       = ack_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;

    if (stop) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_d     = 1'b0;
      bit_cnt_d = '0;
    end else if (start) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      ack_d     = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
              rw_d     = shreg_q[0];
              busy_d   = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d  = ST_RD_DATA;
              shreg_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = ST_WR_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        // ack_q marks the ACK bit that follows each received byte.
        ST_WR_PTR, ST_WR_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (ack_q) begin
              ack_d     = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_WR_DATA;
            end else if (bit_cnt_q == 4'd8) begin
              ack_d    = 1'b1;
              sda_oe_d = 1'b1;
              if (state_q == ST_WR_PTR) begin
                ptr_d = shreg_q[AW-1:0];
              end else begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = shreg_q;
                ptr_d       = ptr_q + AW'(1);
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_RD_ACK;
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + AW'(1);
              bit_cnt_d = '0;
            end else if (bit_cnt_q != 4'd0) begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[7:1], sda_f};
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if (shreg_q[0] == ACK) begin
              state_d  = ST_RD_DATA;
              shreg_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        default:   state_d  = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50_clk) begin
    if (reset_50_reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      ack_q       <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Read port samples before the write lands, so a same-index collision shows old then new.
  always_ff @(posedge clk_50_clk) begin
    if (reset_50_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      fab_rd_data_q <= '0;
    end else begin
      if (reg_we) regs_q[ptr_q] <= shreg_q;
      fab_rd_data_q <= regs_q[bus.fab_rd_addr];
    end
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.busy        = busy_q;
  assign bus.wr_strobe   = wr_strobe_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.fab_rd_data = fab_rd_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench: bit-level I2C initiator BFM driving the target, checked against an array/pointer model.
module tb_i2c_target_regfile;

  localparam int NUM_REGS = 16;
  localparam int AW       = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  logic [AW-1:0] fab_addr = '0;
  int q = 31;

  always #10 clk = ~clk;

  i2c_target_regfile_if #(.AW(AW)) bus();
  assign bus.scl_i       = scl_drv;
  assign bus.sda_i       = sda_drv & ~bus.sda_oe;
  assign bus.fab_rd_addr = fab_addr;

  i2c_target_regfile #(.DEV_ADDR(7'h3C), .NUM_REGS(NUM_REGS), .FILT_LEN(3)) dut (
    .clk_50_clk     (clk),
    .reset_50_reset (rst),
    .bus            (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]      mreg [NUM_REGS];
  int              mptr;
  logic [7:0]      wbuf[$];
  logic [7:0]      rbuf[$];
  logic [7:0]      exp_rd[$];
  logic [AW+7:0]   exp_sq[$];
  logic [AW+7:0]   sq[$];
  logic            oe_seen, busy_seen, coll_pend, coll_seen;
  logic [7:0]      coll_old, coll_new;

  always @(negedge clk) begin
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.busy) busy_seen = 1'b1;
    if (bus.wr_strobe) begin
      sq.push_back({bus.wr_addr, bus.wr_data});
      if (bus.wr_addr == fab_addr) begin
        coll_old  = bus.fab_rd_data;
        coll_pend = 1'b1;
      end
    end else if (coll_pend) begin
      coll_new  = bus.fab_rd_data;
      coll_pend = 1'b0;
      coll_seen = 1'b1;
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, input bit glitch, output logic r);
    wq(q); sda_drv = b;
    wq(q); scl_drv = 1'b1;
    wq(q); r = bus.sda_i;
    if (glitch) begin
      sda_drv = ~b; wq(1); sda_drv = b;
    end
    wq(q); scl_drv = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl_drv == 1'b0) begin
      wq(q); sda_drv = 1'b1;
      wq(q); scl_drv = 1'b1;
    end
    wq(q); sda_drv = 1'b0;
    wq(q); scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(q); sda_drv = 1'b0;
    wq(q); scl_drv = 1'b1;
    wq(q); sda_drv = 1'b1;
    wq(2 * q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit glitch, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], glitch && (i == 7), r);
    bit_x(1'b1, 1'b0, r);
    acked = (r == 1'b0);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, 1'b0, r);
      d[i] = r;
    end
    bit_x(nack, 1'b0, r);
  endtask

  // Address + pointer byte + wbuf data bytes; returns how many bytes went un-ACKed.
  task automatic do_write(input logic [7:0] p, input bit do_stop, input bit glitch, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    wr_byte({7'h3C, 1'b0}, 1'b0, a); if (!a) nacks++;
    wr_byte(p, 1'b0, a);             if (!a) nacks++;
    foreach (wbuf[k]) begin
      wr_byte(wbuf[k], glitch && (k == 0), a);
      if (!a) nacks++;
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic do_read(input int n, output logic acked, output logic oe_after);
    logic [7:0] d;
    rbuf.delete();
    i2c_start();
    wr_byte({7'h3C, 1'b1}, 1'b0, acked);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, d);
      rbuf.push_back(d);
    end
    wq(q / 2);
    oe_after = bus.sda_oe;
    i2c_stop();
  endtask

  task automatic model_write(input logic [7:0] p);
    mptr = int'(p) % NUM_REGS;
    exp_sq.delete();
    foreach (wbuf[k]) begin
      mreg[mptr] = wbuf[k];
      exp_sq.push_back({AW'(mptr), wbuf[k]});
      mptr = (mptr + 1) % NUM_REGS;
    end
  endtask

  task automatic model_read(input int n);
    exp_rd.delete();
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back(mreg[mptr]);
      mptr = (mptr + 1) % NUM_REGS;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wq(5); rst = 1'b0; wq(2);
    for (int i = 0; i < NUM_REGS; i++) mreg[i] = 8'h00;
    mptr = 0;
    total++; if (bus.sda_oe !== 1'b0)    begin bad++; $display("FAIL reset_sda_oe got=%b exp=0", bus.sda_oe); end
    total++; if (bus.wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_wr_strobe got=%b exp=0", bus.wr_strobe); end
    total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    fab_addr = AW'(5); wq(1);
    total++; if (bus.fab_rd_data !== 8'h00) begin bad++; $display("FAIL reset_fab_rd got=%h exp=00", bus.fab_rd_data); end
  endtask

  task automatic test_write_basic();
    int n;
    logic [7:0] old3;
    q = 125;
    fab_addr = AW'(3);
    wq(2);
    sq.delete(); coll_seen = 1'b0; coll_pend = 1'b0; busy_seen = 1'b0;
    wbuf = '{8'hA5, 8'h5A};
    old3 = mreg[3];
    do_write(8'h02, 1'b1, 1'b0, n);
    model_write(8'h02);
    total++; if (n != 0) begin bad++; $display("FAIL wb_acks got=%0d exp=0 missing", n); end
    total++; if (sq.size() != exp_sq.size()) begin bad++; $display("FAIL wb_strobes got=%0d exp=%0d", sq.size(), exp_sq.size()); end
    foreach (exp_sq[k]) begin
      total++;
      if (k >= sq.size() || sq[k] !== exp_sq[k]) begin
        bad++; $display("FAIL wb_strobe%0d got=%h exp=%h", k, (k < sq.size()) ? sq[k] : '0, exp_sq[k]);
      end
    end
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL wb_busy_seen got=%b exp=1", busy_seen); end
    total++; if (coll_seen !== 1'b1 || coll_old !== old3 || coll_new !== 8'h5A) begin
      bad++; $display("FAIL wb_collision got=%b/%h/%h exp=1/%h/5a", coll_seen, coll_old, coll_new, old3);
    end
    wq(1);
    total++; if (bus.fab_rd_data !== mreg[3]) begin bad++; $display("FAIL wb_fab_rd3 got=%h exp=%h", bus.fab_rd_data, mreg[3]); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wb_busy_after_stop got=%b exp=0", bus.busy); end
    q = 31;
  endtask

  task automatic test_wrap_read();
    int n;
    logic a, oe;
    wbuf.delete();
    for (int k = 0; k < 4; k++) wbuf.push_back(8'($urandom));
    do_write(8'h0E, 1'b1, 1'b0, n);
    model_write(8'h0E);
    total++; if (n != 0) begin bad++; $display("FAIL wrap_fill_acks got=%0d exp=0 missing", n); end
    wbuf.delete();
    do_write(8'hFF, 1'b0, 1'b0, n);
    model_write(8'hFF);
    do_read(3, a, oe);
    model_read(3);
    total++; if (n != 0 || a !== 1'b1) begin bad++; $display("FAIL wrap_addr_acks got=%0d/%b exp=0/1", n, a); end
    foreach (exp_rd[k]) begin
      total++;
      if (k >= rbuf.size() || rbuf[k] !== exp_rd[k]) begin
        bad++; $display("FAIL wrap_rd%0d got=%h exp=%h", k, (k < rbuf.size()) ? rbuf[k] : 8'h00, exp_rd[k]);
      end
    end
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL wrap_release_after_nack got=%b exp=0", oe); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    sq.delete(); oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    wr_byte({7'h3D, 1'b0}, 1'b0, a);
    wr_byte(8'($urandom), 1'b0, a);
    i2c_stop();
    total++; if (oe_seen !== 1'b0)   begin bad++; $display("FAIL wa_sda_oe got=%b exp=0", oe_seen); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL wa_busy got=%b exp=0", busy_seen); end
    total++; if (sq.size() != 0)     begin bad++; $display("FAIL wa_strobes got=%0d exp=0", sq.size()); end
  endtask

  task automatic test_stop_mid_byte();
    int n;
    logic a, oe, r;
    logic [7:0] p;
    p = 8'($urandom);
    sq.delete();
    wbuf.delete();
    do_write(p, 1'b0, 1'b0, n);
    model_write(p);
    for (int i = 0; i < 4; i++) bit_x(1'($urandom), 1'b0, r);
    i2c_stop();
    total++; if (sq.size() != 0)   begin bad++; $display("FAIL sm_strobes got=%0d exp=0", sq.size()); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sm_busy got=%b exp=0", bus.busy); end
    do_read(3, a, oe);
    model_read(3);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL sm_next_ack got=%b exp=1", a); end
    foreach (exp_rd[k]) begin
      total++;
      if (k >= rbuf.size() || rbuf[k] !== exp_rd[k]) begin
        bad++; $display("FAIL sm_rd%0d got=%h exp=%h", k, (k < rbuf.size()) ? rbuf[k] : 8'h00, exp_rd[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic r;
    logic [7:0] ab;
    ab = {7'h3C, 1'b1};
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_x(ab[i], 1'b0, r);
    wq(q); sda_drv = 1'b1;
    wq(q); scl_drv = 1'b1;
    wq(q);
    total++; if (bus.sda_oe !== 1'b1) begin bad++; $display("FAIL rm_ack_driven got=%b exp=1", bus.sda_oe); end
    rst = 1'b1; wq(1);
    total++; if (bus.sda_oe !== 1'b0 || bus.busy !== 1'b0 || bus.wr_strobe !== 1'b0) begin
      bad++; $display("FAIL rm_outputs got=%b%b%b exp=000", bus.sda_oe, bus.busy, bus.wr_strobe);
    end
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mreg[i] = 8'h00;
    mptr = 0;
    wq(q); scl_drv = 1'b0;
    i2c_stop();
    for (int i = 0; i < NUM_REGS; i++) begin
      fab_addr = AW'(i); wq(1);
      total++; if (bus.fab_rd_data !== mreg[i]) begin bad++; $display("FAIL rm_reg%0d got=%h exp=%h", i, bus.fab_rd_data, mreg[i]); end
    end
  endtask

  task automatic test_glitch();
    int n;
    logic [7:0] p;
    p = 8'($urandom);
    sq.delete();
    wbuf.delete();
    wbuf.push_back(8'($urandom) | 8'h80);
    wbuf.push_back(8'($urandom));
    do_write(p, 1'b1, 1'b1, n);
    model_write(p);
    total++; if (n != 0) begin bad++; $display("FAIL gl_acks got=%0d exp=0 missing", n); end
    total++; if (sq.size() != exp_sq.size()) begin bad++; $display("FAIL gl_strobes got=%0d exp=%0d", sq.size(), exp_sq.size()); end
    foreach (exp_sq[k]) begin
      total++;
      if (k >= sq.size() || sq[k] !== exp_sq[k]) begin
        bad++; $display("FAIL gl_strobe%0d got=%h exp=%h", k, (k < sq.size()) ? sq[k] : '0, exp_sq[k]);
      end
    end
  endtask

  task automatic test_random();
    int n, len;
    logic a, oe;
    logic [7:0] p;
    for (int it = 0; it < 2; it++) begin
      p = 8'($urandom);
      len = $urandom_range(1, 3);
      sq.delete();
      wbuf.delete();
      for (int k = 0; k < len; k++) wbuf.push_back(8'($urandom));
      do_write(p, 1'b1, 1'b0, n);
      model_write(p);
      total++; if (n != 0 || sq.size() != exp_sq.size()) begin
        bad++; $display("FAIL rnd%0d_write got=%0d/%0d exp=0/%0d", it, n, sq.size(), exp_sq.size());
      end
      foreach (exp_sq[k]) begin
        total++;
        if (k >= sq.size() || sq[k] !== exp_sq[k]) begin
          bad++; $display("FAIL rnd%0d_strobe%0d got=%h exp=%h", it, k, (k < sq.size()) ? sq[k] : '0, exp_sq[k]);
        end
      end
      p = 8'($urandom);
      wbuf.delete();
      do_write(p, 1'b0, 1'b0, n);
      model_write(p);
      len = $urandom_range(1, 3);
      do_read(len, a, oe);
      model_read(len);
      foreach (exp_rd[k]) begin
        total++;
        if (k >= rbuf.size() || rbuf[k] !== exp_rd[k]) begin
          bad++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, k, (k < rbuf.size()) ? rbuf[k] : 8'h00, exp_rd[k]);
        end
      end
    end
  endtask

  initial begin
    oe_seen = 1'b0; busy_seen = 1'b0; coll_pend = 1'b0; coll_seen = 1'b0;
    coll_old = 8'h00; coll_new = 8'h00;
    test_reset();
    test_write_basic();
    test_wrap_read();
    test_wrong_addr();
    test_stop_mid_byte();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
